// File: rtl/toy_dmem_responder.sv
// toy_dmem_responder
//   Data-memory responder for the RISC_TOY 5-stage pipeline. Services the
//   active-low DREQ/DRW requests from the execute/memory stage against a
//   word-organised array, inserting LATENCY wait states (DSTALL high) per
//   access and returning read data with a one-cycle DVALID pulse.
//
// Ports
//   CLK     in   clock, rising edge
//   RSTN    in   asynchronous active-low reset
//   DREQ    in   access request, active low
//   DRW     in   1 = write, 0 = read (sampled only with DREQ=0)
//   DADDR   in   byte address; word index = DADDR[AW+1:2]
//   DBE     in   write byte enables
//   DWDATA  in   write data
//   DRDATA  out  registered read data, holds last read value
//   DVALID  out  one-cycle pulse when DRDATA updated
//   DSTALL  out  pipeline hold request (combinational)
module toy_dmem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 0,
  parameter int CW      = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [31:0] DADDR,
  input  logic [3:0]  DBE,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        DVALID,
  output logic        DSTALL
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CW-1:0] LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, fire;

  logic            lat_rw;
  logic [AW-1:0]   lat_idx;
  logic [3:0]      lat_be;
  logic [31:0]     lat_wdata;

  logic            acc_rw;
  logic [AW-1:0]   acc_idx;
  logic [3:0]      acc_be;
  logic [31:0]     acc_wdata;

  logic [31:0]     mem [2**AW];

  // Address bits outside the word index alias by design.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{DADDR[31:AW+2], DADDR[1:0]};

  // Zero latency completes straight from the ports; otherwise only the
  // copy latched at accept time is used, so port changes during WAIT are inert.
  always_comb begin
    if (LATENCY == 0) begin
      acc_rw    = DRW;
      acc_idx   = DADDR[AW+1:2];
      acc_be    = DBE;
      acc_wdata = DWDATA;
    end else begin
      acc_rw    = lat_rw;
      acc_idx   = lat_idx;
      acc_be    = lat_be;
      acc_wdata = lat_wdata;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    fire     = 1'b0;
    DSTALL   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!DREQ) begin
          if (LATENCY == 0) begin
            fire = 1'b1;
          end else begin
            accept   = 1'b1;
            DSTALL   = 1'b1;
            cnt_nx   = LOAD;
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          DSTALL = 1'b1;
          cnt_nx = cnt - 1'b1;
        end else begin
          fire     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Hold everything quiet while in reset, including a pending access.
    if (!RSTN) begin
      DSTALL = 1'b0;
      fire   = 1'b0;
      accept = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_idx   <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_rw    <= DRW;
        lat_idx   <= DADDR[AW+1:2];
        lat_be    <= DBE;
        lat_wdata <= DWDATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fire && acc_rw) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DRDATA <= '0;
      DVALID <= 1'b0;
    end else begin
      DVALID <= fire && !acc_rw;
      if (fire && !acc_rw) DRDATA <= mem[acc_idx];
    end
  end

endmodule

// File: tb/tb_toy_dmem_responder.sv
// tb_toy_dmem_responder
//   Directed bench for toy_dmem_responder: one instance at LATENCY=0 and one
//   at LATENCY=3, sharing clock and reset, with hand-computed expectations.
module tb_toy_dmem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        req0, rw0, vl0, st0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;
  logic        req3, rw3, vl3, st3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  be3;

  int checks = 0;
  int errors = 0;

  toy_dmem_responder #(.AW(10), .LATENCY(0), .CW(4)) d0 (
    .CLK(clk), .RSTN(rstn), .DREQ(req0), .DRW(rw0), .DADDR(addr0),
    .DBE(be0), .DWDATA(wd0), .DRDATA(rd0), .DVALID(vl0), .DSTALL(st0)
  );

  toy_dmem_responder #(.AW(10), .LATENCY(3), .CW(4)) d3 (
    .CLK(clk), .RSTN(rstn), .DREQ(req3), .DRW(rw3), .DADDR(addr3),
    .DBE(be3), .DWDATA(wd3), .DRDATA(rd3), .DVALID(vl3), .DSTALL(st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full LATENCY=3 access with DREQ held low through the stall; returns in the
  // cycle after completion (where a read's DVALID is visible).
  task automatic acc3(input logic rw, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    req3 = 1'b0; rw3 = rw; addr3 = a; be3 = be; wd3 = wd;
    tick; tick; tick;
    req3 = 1'b1;
    tick;
  endtask

  initial begin
    rstn = 1'b0;
    req0 = 1'b1; rw0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
    req3 = 1'b1; rw3 = 1'b0; addr3 = '0; be3 = '0; wd3 = '0;
    tick; tick;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_vl0", {31'b0, vl0}, 32'h0);
    chk("rst_st0", {31'b0, st0}, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    chk("rst_vl3", {31'b0, vl3}, 32'h0);
    req3 = 1'b0;
    #1 chk("rst_st3_req_low", {31'b0, st3}, 32'h0);
    req3 = 1'b1;
    rstn = 1'b1;
    tick;

    // LATENCY=0: write then read back on consecutive cycles
    req0 = 1'b0; rw0 = 1'b1; addr0 = 32'h10; be0 = 4'hF; wd0 = 32'hDEADBEEF;
    #1 chk("l0_wr_st", {31'b0, st0}, 32'h0);
    tick;
    chk("l0_wr_no_vl", {31'b0, vl0}, 32'h0);
    rw0 = 1'b0;
    #1 chk("l0_rd_st", {31'b0, st0}, 32'h0);
    tick;
    chk("l0_rd_vl", {31'b0, vl0}, 32'h1);
    chk("l0_rd_data", rd0, 32'hDEADBEEF);
    req0 = 1'b1;
    tick;
    chk("l0_vl_pulse", {31'b0, vl0}, 32'h0);

    // Byte enables, write leaves DRDATA alone, DBE=0 no-op
    req0 = 1'b0; rw0 = 1'b1; addr0 = 32'h20; be0 = 4'hF; wd0 = 32'h11223344;
    tick;
    be0 = 4'b0101; wd0 = 32'hAABBCCDD;
    tick;
    chk("be_wr_keeps_rd", rd0, 32'hDEADBEEF);
    chk("be_wr_no_vl", {31'b0, vl0}, 32'h0);
    be0 = 4'b0000; wd0 = 32'hFFFFFFFF;
    tick;
    rw0 = 1'b0;
    tick;
    chk("be_merge", rd0, 32'h11BB33DD);
    chk("be_merge_vl", {31'b0, vl0}, 32'h1);

    // Aliasing: 0x1003 maps to word 0
    rw0 = 1'b1; addr0 = 32'h0000_1003; be0 = 4'hF; wd0 = 32'h5;
    tick;
    rw0 = 1'b0; addr0 = 32'h0;
    tick;
    chk("alias", rd0, 32'h5);
    req0 = 1'b1;
    tick;

    // LATENCY=3: preload, then read with stall timing checks
    acc3(1'b1, 32'h10, 4'hF, 32'hCAFEF00D);
    chk("l3_wr_no_vl", {31'b0, vl3}, 32'h0);
    req3 = 1'b0; rw3 = 1'b0; addr3 = 32'h10;
    #1 chk("l3_st_c1", {31'b0, st3}, 32'h1);
    tick;
    chk("l3_st_c2", {31'b0, st3}, 32'h1);
    tick;
    chk("l3_st_c3", {31'b0, st3}, 32'h1);
    chk("l3_vl_early", {31'b0, vl3}, 32'h0);
    tick;
    chk("l3_st_fall", {31'b0, st3}, 32'h0);
    chk("l3_vl_at_fall", {31'b0, vl3}, 32'h0);
    req3 = 1'b1;
    tick;
    chk("l3_rd_vl", {31'b0, vl3}, 32'h1);
    chk("l3_rd_data", rd3, 32'hCAFEF00D);
    chk("l3_idle_st", {31'b0, st3}, 32'h0);
    tick;
    chk("l3_vl_pulse", {31'b0, vl3}, 32'h0);

    // Port changes during WAIT are ignored
    acc3(1'b1, 32'h84, 4'hF, 32'h0BADF00D);
    req3 = 1'b0; rw3 = 1'b1; addr3 = 32'h80; be3 = 4'hF; wd3 = 32'h12345678;
    tick;
    rw3 = 1'b0; addr3 = 32'h84; be3 = 4'h0; wd3 = 32'hFFFFFFFF;
    tick; tick;
    req3 = 1'b1;
    tick;
    chk("garb_no_vl", {31'b0, vl3}, 32'h0);
    acc3(1'b0, 32'h80, 4'h0, 32'h0);
    chk("garb_latched", rd3, 32'h12345678);
    acc3(1'b0, 32'h84, 4'h0, 32'h0);
    chk("garb_addr_kept", rd3, 32'h0BADF00D);

    // Reset during the second WAIT cycle drops the write
    acc3(1'b1, 32'h40, 4'hF, 32'h0BEEF040);
    req3 = 1'b0; rw3 = 1'b1; addr3 = 32'h40; be3 = 4'hF; wd3 = 32'h77;
    tick; tick;
    chk("mid_wait_st", {31'b0, st3}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("rst_wait_st", {31'b0, st3}, 32'h0);
    chk("rst_wait_vl", {31'b0, vl3}, 32'h0);
    req3 = 1'b1;
    tick; tick;
    chk("rst_wait_no_vl", {31'b0, vl3}, 32'h0);
    rstn = 1'b1;
    tick;
    acc3(1'b0, 32'h40, 4'h0, 32'h0);
    chk("rst_drop_vl", {31'b0, vl3}, 32'h1);
    chk("rst_drop_data", rd3, 32'h0BEEF040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
